// File: rtl/oc8051_defines.sv
// Shared oc8051 definitions used by the interrupt service sequencer.
package oc8051_defines;

   typedef enum logic [2:0] {
      OC8051_ISEQ_IDLE    = 3'd0,
      OC8051_ISEQ_WAIT    = 3'd1,
      OC8051_ISEQ_DEFER   = 3'd2,
      OC8051_ISEQ_PUSH_LO = 3'd3,
      OC8051_ISEQ_PUSH_HI = 3'd4,
      OC8051_ISEQ_VECT    = 3'd5
   } oc8051_iseq_state_e;

   localparam int unsigned OC8051_ISEQ_NEST_MAX = 2;

endpackage

// File: rtl/oc8051_int_seq.sv
// Interrupt service sequencer: waits for an instruction boundary, pushes the
// return PC onto the stack, loads the vector and tracks nesting depth.
module oc8051_int_seq
   import oc8051_defines::*;
#(
   parameter logic [7:0]  VEC_HI   = 8'h00,
   parameter int unsigned MAX_NEST = OC8051_ISEQ_NEST_MAX
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        int_req,
   input  logic [7:0]  int_vec,
   input  logic        instr_end,
   input  logic        block_int,
   input  logic        reti,
   input  logic [15:0] pc,
   input  logic [7:0]  sp,
   input  logic        ram_rdy,
   output logic        stall,
   output logic        ram_wr,
   output logic [7:0]  ram_addr,
   output logic [7:0]  ram_data,
   output logic        sp_wr,
   output logic [7:0]  sp_new,
   output logic        pc_load,
   output logic [15:0] pc_new,
   output logic        ack,
   output logic [1:0]  depth
);

   localparam logic [1:0] NEST_MAX = 2'(MAX_NEST);

   oc8051_iseq_state_e state_q, state_d;
   logic        pend_vld_q, pend_vld_d;
   logic [7:0]  pend_vec_q, pend_vec_d;
   logic [7:0]  work_vec_q, work_vec_d;
   logic [15:0] ret_pc_q, ret_pc_d;
   logic [1:0]  depth_q, depth_d;
   logic        consume;

   // Pending slot: a newer request always overwrites, even in the consume cycle.
   always_comb begin
      pend_vld_d = pend_vld_q;
      pend_vec_d = pend_vec_q;
      if (consume) pend_vld_d = 1'b0;
      if (int_req) begin
         pend_vld_d = 1'b1;
         pend_vec_d = int_vec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_vld_q <= 1'b0;
         pend_vec_q <= '0;
      end else begin
         pend_vld_q <= pend_vld_d;
         pend_vec_q <= pend_vec_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ret_pc_d   = ret_pc_q;
      work_vec_d = work_vec_q;
      consume    = 1'b0;
      stall      = 1'b0;
      ram_wr     = 1'b0;
      ram_addr   = '0;
      ram_data   = '0;
      sp_wr      = 1'b0;
      sp_new     = '0;
      pc_load    = 1'b0;
      pc_new     = '0;
      ack        = 1'b0;
      case (state_q)
         OC8051_ISEQ_IDLE: begin
            // Looking at int_req directly lets WAIT see the very next instr_end.
            if (pend_vld_q || int_req) state_d = OC8051_ISEQ_WAIT;
         end
         OC8051_ISEQ_WAIT: begin
            ret_pc_d = pc;
            if (instr_end) begin
               if (block_int) begin
                  state_d = OC8051_ISEQ_DEFER;
               end else begin
                  state_d = OC8051_ISEQ_PUSH_LO;
                  consume = 1'b1;
               end
            end
         end
         OC8051_ISEQ_DEFER: begin
            // Return address must follow the deferred instruction.
            ret_pc_d = pc;
            if (instr_end) begin
               state_d = OC8051_ISEQ_PUSH_LO;
               consume = 1'b1;
            end
         end
         OC8051_ISEQ_PUSH_LO: begin
            stall    = 1'b1;
            ram_wr   = 1'b1;
            ram_addr = sp + 8'd1;
            ram_data = ret_pc_q[7:0];
            if (ram_rdy) state_d = OC8051_ISEQ_PUSH_HI;
         end
         OC8051_ISEQ_PUSH_HI: begin
            stall    = 1'b1;
            ram_wr   = 1'b1;
            ram_addr = sp + 8'd2;
            ram_data = ret_pc_q[15:8];
            if (ram_rdy) state_d = OC8051_ISEQ_VECT;
         end
         OC8051_ISEQ_VECT: begin
            stall   = 1'b1;
            pc_load = 1'b1;
            pc_new  = {VEC_HI, work_vec_q};
            sp_wr   = 1'b1;
            sp_new  = sp + 8'd2;
            ack     = 1'b1;
            state_d = OC8051_ISEQ_IDLE;
         end
         default: state_d = OC8051_ISEQ_IDLE;
      endcase
      if (consume) work_vec_d = pend_vec_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= OC8051_ISEQ_IDLE;
         ret_pc_q   <= '0;
         work_vec_q <= '0;
      end else begin
         state_q    <= state_d;
         ret_pc_q   <= ret_pc_d;
         work_vec_q <= work_vec_d;
      end
   end

   always_comb begin
      depth_d = depth_q;
      if ((state_q == OC8051_ISEQ_VECT) && !reti) begin
         if (depth_q < NEST_MAX) depth_d = depth_q + 2'd1;
      end else if (reti && (state_q != OC8051_ISEQ_VECT)) begin
         if (depth_q != '0) depth_d = depth_q - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) depth_q <= '0;
      else     depth_q <= depth_d;
   end

   assign depth = depth_q;

endmodule

// File: tb/tb_oc8051_int_seq.sv
// Randomized self-checking bench for oc8051_int_seq against a transaction-level model.
module tb_oc8051_int_seq;

   localparam logic [7:0] VEC_HI = 8'h00;

   logic        clk, rst;
   logic        int_req, instr_end, block_int, reti, ram_rdy;
   logic [7:0]  int_vec, sp;
   logic [15:0] pc;
   logic        stall, ram_wr, sp_wr, pc_load, ack;
   logic [7:0]  ram_addr, ram_data, sp_new;
   logic [15:0] pc_new;
   logic [1:0]  depth;
   logic [46:0] outs;

   typedef struct {
      int unsigned c;
      logic [15:0] a;
      logic [15:0] b;
   } ev_t;

   ev_t         wr_q[$];
   ev_t         ack_q[$];
   int unsigned cyc;
   int unsigned n_chk, n_fail;
   int          exp_depth;

   oc8051_int_seq #(.VEC_HI(VEC_HI), .MAX_NEST(2)) dut (
      .clk(clk), .rst(rst), .int_req(int_req), .int_vec(int_vec),
      .instr_end(instr_end), .block_int(block_int), .reti(reti), .pc(pc),
      .sp(sp), .ram_rdy(ram_rdy), .stall(stall), .ram_wr(ram_wr),
      .ram_addr(ram_addr), .ram_data(ram_data), .sp_wr(sp_wr), .sp_new(sp_new),
      .pc_load(pc_load), .pc_new(pc_new), .ack(ack), .depth(depth)
   );

   assign outs = {stall, ram_wr, ram_addr, ram_data, sp_wr, sp_new, pc_load, pc_new, ack, depth};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observed stack writes and service acknowledges
   always @(negedge clk) begin
      if (!rst) begin
         if (ram_wr) chk("wr_stall", stall, 1'b1);
         if (ram_wr && ram_rdy) wr_q.push_back('{c: cyc, a: {8'h00, ram_addr}, b: {8'h00, ram_data}});
         if (ack || pc_load || sp_wr) begin
            chk("ack_ctl", {ack, pc_load, sp_wr, stall, ram_wr}, 5'b11110);
            if (ack) ack_q.push_back('{c: cyc, a: pc_new, b: {8'h00, sp_new}});
         end
      end
   end

   task automatic cyc1();
      @(posedge clk);
      #1;
      int_req   = 1'b0;
      instr_end = 1'b0;
      block_int = 1'b0;
      reti      = 1'b0;
   endtask

   task automatic pulse_reti(input string tg);
      reti = 1'b1;
      cyc1();
      exp_depth = (exp_depth > 0) ? exp_depth - 1 : 0;
      chk(tg, depth, exp_depth);
   endtask

   // Called at the start of the first push cycle (te+1); expects ack at te+3+bp.
   task automatic finish_seq(input string tg, input int unsigned te, input int unsigned bp,
                             input logic [7:0] vec, input logic [15:0] pcv, input logic [7:0] spv,
                             input bit rv, input bit inj, input logic [7:0] iv);
      int unsigned ea;
      logic [7:0]  s1, s2;
      ea = te + 3 + bp;
      s1 = spv + 8'd1;
      s2 = spv + 8'd2;
      if (bp != 0) begin
         ram_rdy = 1'b0;
         repeat (bp) begin
            @(negedge clk);
            chk({tg, ".hold"}, {stall, ram_wr, ram_addr, ram_data, ack}, {1'b1, 1'b1, s1, pcv[7:0], 1'b0});
            cyc1();
         end
         ram_rdy = 1'b1;
      end
      while (cyc < ea) begin
         if (inj && cyc == ea - 1) begin
            int_req = 1'b1;
            int_vec = iv;
         end
         cyc1();
      end
      if (rv) reti = 1'b1;
      cyc1();
      if (!rv) exp_depth = (exp_depth < 2) ? exp_depth + 1 : 2;
      while (cyc < ea + 2) cyc1();
      if (!inj) instr_end = 1'b1;
      repeat (4) cyc1();
      chk({tg, ".nwr"}, wr_q.size(), 2);
      if (wr_q.size() >= 2) begin
         chk({tg, ".wr_lo"}, {wr_q[0].a, wr_q[0].b}, {8'h00, s1, 8'h00, pcv[7:0]});
         chk({tg, ".wr_hi"}, {wr_q[1].a, wr_q[1].b}, {8'h00, s2, 8'h00, pcv[15:8]});
      end
      chk({tg, ".nack"}, ack_q.size(), 1);
      if (ack_q.size() >= 1) begin
         chk({tg, ".ack_cyc"}, ack_q[0].c, ea);
         chk({tg, ".pc_new"}, ack_q[0].a, {VEC_HI, vec});
         chk({tg, ".sp_new"}, ack_q[0].b, {8'h00, s2});
      end
      chk({tg, ".depth"}, depth, exp_depth);
   endtask

   task automatic serve(input string tg, input logic [7:0] vec, input logic [15:0] pcv,
                        input logic [7:0] spv, input bit ow, input logic [7:0] v0, input bit blk,
                        input int unsigned gap, input int unsigned bp, input bit rv);
      int unsigned te;
      pc = pcv;
      sp = spv;
      wr_q.delete();
      ack_q.delete();
      if (ow) begin
         int_vec = v0;
         int_req = 1'b1;
         cyc1();
      end
      int_vec = vec;
      int_req = 1'b1;
      cyc1();
      repeat (gap) begin
         @(negedge clk);
         chk({tg, ".wait"}, {stall, ram_wr, ack}, 3'b000);
         cyc1();
      end
      if (blk) begin
         instr_end = 1'b1;
         block_int = 1'b1;
         cyc1();
         repeat (gap) begin
            @(negedge clk);
            chk({tg, ".defer"}, {stall, ram_wr, ack}, 3'b000);
            cyc1();
         end
      end
      te = cyc;
      instr_end = 1'b1;
      cyc1();
      finish_seq(tg, te, bp, vec, pcv, spv, rv, 1'b0, 8'h00);
   endtask

   initial begin
      int unsigned te;
      rst = 1'b0; int_req = 1'b0; int_vec = '0; instr_end = 1'b0; block_int = 1'b0;
      reti = 1'b0; pc = '0; sp = '0; ram_rdy = 1'b1;
      n_chk = 0; n_fail = 0; exp_depth = 0;
      #2 rst = 1'b1;
      #1 chk("rst_outs", outs, '0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_release", outs, '0);

      serve("basic", 8'h0B, 16'h1234, 8'h07, 1'b0, 8'h00, 1'b0, 0, 0, 1'b0);
      serve("blk", 8'h21, 16'h2345, 8'h10, 1'b0, 8'h00, 1'b1, 1, 0, 1'b0);
      pulse_reti("reti_a");
      pulse_reti("reti_b");
      pulse_reti("reti_floor");
      serve("bp", 8'h2B, 16'h5A6B, 8'h20, 1'b0, 8'h00, 1'b0, 0, 3, 1'b0);
      pulse_reti("reti_c");

      // Nested: second request arrives during PUSH_HI and waits for a fresh instr_end
      pc = 16'h0456; sp = 8'h30; wr_q.delete(); ack_q.delete();
      int_vec = 8'h03; int_req = 1'b1; cyc1();
      te = cyc; instr_end = 1'b1; cyc1();
      finish_seq("nest1", te, 0, 8'h03, 16'h0456, 8'h30, 1'b0, 1'b1, 8'h13);
      pc = 16'h0005; sp = 8'h32; wr_q.delete(); ack_q.delete();
      repeat (2) begin
         @(negedge clk);
         chk("nest.gap", {stall, ram_wr, ack}, 3'b000);
         cyc1();
      end
      te = cyc; instr_end = 1'b1; cyc1();
      finish_seq("nest2", te, 0, 8'h13, 16'h0005, 8'h32, 1'b0, 1'b0, 8'h00);
      pulse_reti("nest_reti1");
      pulse_reti("nest_reti2");

      serve("wrap", 8'h1B, 16'hBEEF, 8'hFF, 1'b0, 8'h00, 1'b0, 0, 0, 1'b0);
      serve("ovw", 8'h0B, 16'h4321, 8'h50, 1'b1, 8'h03, 1'b0, 0, 0, 1'b0);
      serve("reti_vect", 8'h33, 16'h7788, 8'h60, 1'b0, 8'h00, 1'b0, 1, 1, 1'b1);

      // Asynchronous reset in PUSH_HI
      pc = 16'hABCD; sp = 8'h40; wr_q.delete(); ack_q.delete();
      int_vec = 8'h23; int_req = 1'b1; cyc1();
      instr_end = 1'b1; cyc1();
      cyc1();
      #2 rst = 1'b1;
      #1 chk("midrst_outs", outs, '0);
      exp_depth = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) cyc1();
      chk("midrst_nack", ack_q.size(), 0);
      chk("midrst_nwr", wr_q.size(), 1);
      serve("post_rst", 8'h0B, 16'h1111, 8'h07, 1'b0, 8'h00, 1'b0, 0, 0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) pulse_reti("rnd_reti");
         serve("rnd", 8'($urandom), 16'($urandom), 8'($urandom), $urandom_range(0, 3) == 0,
               8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2),
               $urandom_range(0, 3), $urandom_range(0, 5) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
